// File: rtl/mod_exp_ctrl.sv
`timescale 1ns/1ps
// Square-and-multiply sequencer: scans the exponent MSB-first and drives an external
// modular multiplier to compute base^exp mod modulus, one multiply outstanding at a time.
module mod_exp_ctrl #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] in_base_tdata,
    input  logic [SIZE-1:0] in_exp_tdata,
    input  logic [SIZE-1:0] in_mod_tdata,
    input  logic            in_tvalid,
    output logic            in_tready,
    output logic [SIZE-1:0] mm_multiplier_tdata,
    output logic [SIZE-1:0] mm_multiplicand_tdata,
    output logic [SIZE-1:0] mm_modulus_tdata,
    output logic            mm_tvalid,
    input  logic            mm_tready,
    input  logic [SIZE-1:0] mm_result_tdata,
    input  logic            mm_result_tvalid,
    output logic            mm_result_tready,
    output logic [SIZE-1:0] out_tdata,
    output logic            out_tvalid,
    input  logic            out_tready,
    output logic            busy
);
    localparam int CNT_W = $clog2(SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SQ_REQ,
        S_SQ_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SIZE-1:0]  r_e, r_b, r_m, r_acc;
    logic [SIZE-1:0]  w_e_nxt, w_b_nxt, w_m_nxt, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_first, w_first_nxt;
    logic             w_mod_trivial;
    logic             w_e_top;
    logic [SIZE-1:0]  w_e_shl;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_mod_trivial = (r_m <= SIZE'(1));
    assign w_e_top       = r_e[SIZE-1];
    assign w_e_shl       = {r_e[SIZE-2:0], 1'b0};
    assign w_cnt_dec     = r_cnt - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_e     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_e     <= w_e_nxt;
            r_b     <= w_b_nxt;
            r_m     <= w_m_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        w_e_nxt               = r_e;
        w_b_nxt               = r_b;
        w_m_nxt               = r_m;
        w_acc_nxt             = r_acc;
        w_cnt_nxt             = r_cnt;
        w_first_nxt           = r_first;
        in_tready             = 1'b0;
        mm_tvalid             = 1'b0;
        mm_result_tready      = 1'b0;
        out_tvalid            = 1'b0;
        mm_multiplicand_tdata = r_b;

        case (r_state)
            S_IDLE: begin
                // Gated so the port reads 0 while reset is held, even though state is IDLE.
                in_tready = ~rst;
                if (in_tvalid && in_tready) begin
                    w_b_nxt     = in_base_tdata;
                    w_e_nxt     = in_exp_tdata;
                    w_m_nxt     = in_mod_tdata;
                    w_acc_nxt   = SIZE'(1);
                    w_cnt_nxt   = CNT_W'(SIZE);
                    w_first_nxt = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_mod_trivial) begin
                    w_acc_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else if ((r_e == '0) && r_first) begin
                    w_acc_nxt   = SIZE'(1);
                    w_state_nxt = S_DONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else if (r_first && !w_e_top) begin
                    w_e_nxt   = w_e_shl;
                    w_cnt_nxt = w_cnt_dec;
                end else if (r_first) begin
                    // Leading one: 1*b mod m also reduces a base that is >= m.
                    w_first_nxt = 1'b0;
                    w_state_nxt = S_MUL_REQ;
                end else begin
                    w_state_nxt = S_SQ_REQ;
                end
            end
            S_SQ_REQ: begin
                mm_tvalid             = 1'b1;
                mm_multiplicand_tdata = r_acc;
                if (mm_tready) begin
                    w_state_nxt = S_SQ_WAIT;
                end
            end
            S_SQ_WAIT: begin
                mm_result_tready = 1'b1;
                if (mm_result_tvalid) begin
                    w_acc_nxt = mm_result_tdata;
                    if (w_e_top) begin
                        w_state_nxt = S_MUL_REQ;
                    end else begin
                        w_e_nxt     = w_e_shl;
                        w_cnt_nxt   = w_cnt_dec;
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_MUL_REQ: begin
                mm_tvalid = 1'b1;
                if (mm_tready) begin
                    w_state_nxt = S_MUL_WAIT;
                end
            end
            S_MUL_WAIT: begin
                mm_result_tready = 1'b1;
                if (mm_result_tvalid) begin
                    w_acc_nxt   = mm_result_tdata;
                    w_e_nxt     = w_e_shl;
                    w_cnt_nxt   = w_cnt_dec;
                    w_state_nxt = S_SCAN;
                end
            end
            S_DONE: begin
                out_tvalid = 1'b1;
                if (out_tready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mm_multiplier_tdata = r_acc;
    assign mm_modulus_tdata    = r_m;
    assign out_tdata           = r_acc;
    assign busy                = (r_state != S_IDLE);

endmodule
